instruction: RTL and testbench
==============================

INSTRUCTION -- requirements
Module: instruction

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock for the PC register.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 pc  output  32  current program counter (byte address), registered.
REQ-005 pc_new  output  32  next sequential address, pc + 4, combinational.
REQ-006 inst_code  output  32  instruction word at pc, combinational ROM read.
REQ-007 op  output  6  inst_code[31:26].
REQ-008 rs  output  5  inst_code[25:21].
REQ-009 rt  output  5  inst_code[20:16].
REQ-010 rd  output  5  inst_code[15:11].
REQ-011 shamt  output  5  inst_code[10:6].
REQ-012 func  output  6  inst_code[5:0].
REQ-013 imm  output  16  inst_code[15:0], unextended.
REQ-014 addr  output  26  inst_code[25:0].

Function
REQ-015 Instruction ROM SHALL be 64 words x 32 bits, read asynchronously, indexed by pc[7:2]; pc[1:0] and pc[31:8] are ignored, so addresses alias every 256 bytes.
REQ-016 ROM contents SHALL be fixed: word0 = 32'h00221820, word1 = 32'h8C040008, word2 = 32'h08000000, words 3..63 = 32'h00000000.
REQ-017 pc_new SHALL equal pc + 4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-018 On each rising clk with rst = 0, pc SHALL load the next address per REQ-025/REQ-026; one instruction per cycle, no stalls.
REQ-019 All field outputs SHALL be pure slices of inst_code, valid in the same cycle as pc, with no register stage.
REQ-020 Decode SHALL NOT depend on op; every field is driven for every instruction format.

Reset
REQ-021 On a rising clk with rst = 1, pc SHALL become 32'h00000000; this takes priority over any jump.
REQ-022 The pc register SHALL also power up as 32'h00000000 so that it is defined before the first sampled reset.
REQ-023 After reset: pc = 0, pc_new = 4, inst_code = 32'h00221820.
REQ-024 If rst is asserted mid-program, pc SHALL return to 0 at that edge; ROM contents are unaffected.

Configuration
REQ-025 With INST_JUMP_EN defined: when op = 6'b000010 (j), the next pc SHALL be {pc_new[31:28], addr, 2'b00}; otherwise the next pc is pc_new.
REQ-026 Without INST_JUMP_EN: the next pc SHALL always be pc_new, and j is decoded but not executed.

Verification
REQ-027 Power-up, with rst high 0-10 ns and a 50 ns clock period -> pc = 0, inst_code = 32'h00221820, op = 0, rs = 1, rt = 2, rd = 3, shamt = 0, func = 6'h20.
REQ-028 First rising edge -> pc = 4, pc_new = 8, inst_code = 32'h8C040008, op = 6'h23, rs = 0, rt = 4, imm = 16'h0008.
REQ-029 Second edge -> pc = 8, op = 6'h02, addr = 0; third edge -> pc = 0 with INST_JUMP_EN, pc = 12 with inst_code = 0 without it.
REQ-030 Without INST_JUMP_EN, run 64 edges -> pc = 256 and inst_code = 32'h00221820 (alias of word0).
REQ-031 Assert rst for one edge at pc = 8 -> pc = 0 at that edge, and sequencing resumes normally afterward.

Source files
------------

// File: rtl/instruction.sv
// Instruction fetch stage: PC register, fixed 64-word instruction ROM and field decode.
// Optional macro INST_JUMP_EN enables execution of the j instruction (op 6'b000010).
module instruction (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] pc_new,
    output logic [31:0] inst_code,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic [15:0] imm,
    output logic [25:0] addr
);

    localparam logic [5:0] OP_J = 6'b000010;

    // Power-up value keeps pc defined before the first sampled reset.
    logic [31:0] pc_q = 32'h0000_0000;
    logic [31:0] pc_d;

    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        logic [31:0] w;
        case (idx)
            6'd0:    w = 32'h0022_1820;
            6'd1:    w = 32'h8C04_0008;
            6'd2:    w = 32'h0800_0000;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign pc        = pc_q;
    assign pc_new    = pc_q + 32'd4;
    // Only the word index selects the ROM entry, so addresses alias every 256 bytes.
    assign inst_code = rom_word(pc_q[7:2]);

    assign op    = inst_code[31:26];
    assign rs    = inst_code[25:21];
    assign rt    = inst_code[20:16];
    assign rd    = inst_code[15:11];
    assign shamt = inst_code[10:6];
    assign func  = inst_code[5:0];
    assign imm   = inst_code[15:0];
    assign addr  = inst_code[25:0];

`ifdef INST_JUMP_EN
    always_comb begin
        pc_d = pc_new;
        if (op == OP_J) begin
            pc_d = {pc_new[31:28], addr, 2'b00};
        end
    end
`else
    // j is decoded but never redirects the PC in this build.
    always_comb begin
        pc_d = pc_new;
        if (op == OP_J) begin
            pc_d = pc_new;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 32'h0000_0000;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_instruction.sv
// Scoreboard bench for the instruction fetch stage: randomized reset stimulus,
// behavioural PC/ROM model, monitor comparing every cycle on the falling edge.
module tb_instruction;

    logic        clk;
    logic        rst;
    logic [31:0] pc, pc_new, inst_code;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] rom_m [64];

    instruction dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_new(pc_new), .inst_code(inst_code),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
        .imm(imm), .addr(addr)
    );

    initial clk = 1'b1;
    always #25 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] p);
        exp_t e;
        e.pc   = p;
        e.pcn  = p + 32'd4;
        e.inst = rom_m[(p / 4) % 64];
        return e;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p);
        logic [31:0] seq;
        logic [31:0] w;
        seq = p + 32'd4;
        w   = rom_m[(p / 4) % 64];
`ifdef INST_JUMP_EN
        if ((w >> 26) == 32'd2) begin
            return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        end
`endif
        return seq;
    endfunction

    // Monitor: one expected response per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("pc",        pc,        e.pc);
                check("pc_new",    pc_new,    e.pcn);
                check("inst_code", inst_code, e.inst);
                check("op",        {26'd0, op},    (e.inst >> 26) % 64);
                check("rs",        {27'd0, rs},    (e.inst >> 21) % 32);
                check("rt",        {27'd0, rt},    (e.inst >> 16) % 32);
                check("rd",        {27'd0, rd},    (e.inst >> 11) % 32);
                check("shamt",     {27'd0, shamt}, (e.inst >> 6) % 32);
                check("func",      {26'd0, func},  e.inst % 64);
                check("imm",       {16'd0, imm},   e.inst % 65536);
                check("addr",      {6'd0, addr},   e.inst % 32'h0400_0000);
            end
        end
    end

    // Stimulus and reference model.
    initial begin
        logic [31:0] mpc;
        int pulse_done;
        for (int i = 0; i < 64; i++) rom_m[i] = 32'h0000_0000;
        rom_m[0] = 32'h0022_1820;
        rom_m[1] = 32'h8C04_0008;
        rom_m[2] = 32'h0800_0000;

        mpc = 32'h0;
        pulse_done = 0;
        rst = 1'b1;
        exp_q.push_back(make_exp(mpc));
        #10 rst = 1'b0;

        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if (rst) mpc = 32'h0;
            else     mpc = model_next(mpc);
            exp_q.push_back(make_exp(mpc));
            #1;
            if (c == 69) rst = 1'b1;
            else if (c > 70 && pulse_done == 0 && mpc == 32'd8) begin
                rst = 1'b1;
                pulse_done = 1;
            end
            else if (c > 90) rst = ($urandom_range(0, 7) == 0);
            else rst = 1'b0;
        end

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        check("reset_pulse_seen", pulse_done, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
